rmii_rx_deser: RTL and testbench

//  RMII receive front end. Turns 2-bit RMII dibits into Ethernet frame bytes for the Powerlink

---
 rtl/rmii_pkg.sv | 16 +
 rtl/rmii_rx_strobe.sv | 36 +++
 rtl/rmii_rx_deser.sv | 136 +++++++++++++
 tb/tb_rmii_rx_deser.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_pkg.sv
// Shared constants and state encoding for the RMII receive path.
package rmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StBody,
    StDrop
  } rx_state_e;

  localparam logic [1:0] DIB_PRE = 2'b01;
  localparam logic [1:0] DIB_SFD = 2'b11;

  localparam int unsigned DIV10_DEFAULT = 10;

endpackage

// File: rtl/rmii_rx_strobe.sv
// Dibit sample strobe: every clk at 100 Mb/s, once per DIV10 clk at 10 Mb/s.
module rmii_rx_strobe
  import rmii_pkg::*;
#(
  parameter int unsigned DIV10     = DIV10_DEFAULT,
  parameter int unsigned SAMPLE_PH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fast_eth,
  input  logic crs_rise,
  output logic stb
);

  localparam int unsigned DivW = (DIV10 > 1) ? $clog2(DIV10) : 1;

  logic [DivW-1:0] div_q;
  logic [DivW-1:0] div_eff;

  // A carrier rise in idle restarts the divider so the first dibit is sampled mid-cell.
  always_comb begin
    div_eff = crs_rise ? '0 : div_q;
    stb     = fast_eth || (div_eff == DivW'(SAMPLE_PH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (div_eff == DivW'(DIV10 - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_eff + 1'b1;
    end
  end

endmodule

// File: rtl/rmii_rx_deser.sv
// RMII receive deserializer: strips preamble/SFD and emits frame bytes with rdy pulses.
module rmii_rx_deser
  import rmii_pkg::*;
#(
  parameter int unsigned PRE_MAX   = 40,
  parameter int unsigned DIV10     = DIV10_DEFAULT,
  parameter int unsigned SAMPLE_PH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fast_eth,
  input  logic [1:0] rm_rx_data,
  input  logic       rm_crs_dv,
  output logic [7:0] data,
  output logic       rdy,
  output logic       busy,
  output logic       align_err
);

  localparam int unsigned PcntW = $clog2(PRE_MAX + 1);

  logic [1:0]       rxd_q;
  logic             crs_q;
  logic             crs_prev_q;
  rx_state_e        state_q;
  logic [PcntW-1:0] pcnt_q;
  logic [1:0]       dcnt_q;
  logic [1:0]       dcnt_save_q;
  logic [7:0]       sr_q;
  logic             low_q;
  logic             stb;
  logic             crs_rise;

  assign crs_rise = crs_q && !crs_prev_q && (state_q == StIdle);

  rmii_rx_strobe #(
    .DIV10    (DIV10),
    .SAMPLE_PH(SAMPLE_PH)
  ) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .fast_eth(fast_eth),
    .crs_rise(crs_rise),
    .stb     (stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q       <= '0;
      crs_q       <= 1'b0;
      crs_prev_q  <= 1'b0;
      state_q     <= StIdle;
      pcnt_q      <= '0;
      dcnt_q      <= '0;
      dcnt_save_q <= '0;
      sr_q        <= '0;
      low_q       <= 1'b0;
      data        <= '0;
      rdy         <= 1'b0;
      busy        <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      rxd_q      <= rm_rx_data;
      crs_q      <= rm_crs_dv;
      crs_prev_q <= crs_q;
      rdy        <= 1'b0;
      align_err  <= 1'b0;
      if (stb) begin
        unique case (state_q)
          StIdle: begin
            if (crs_q) begin
              low_q <= 1'b0;
              if (rxd_q == DIB_PRE) begin
                state_q <= StPre;
                pcnt_q  <= PcntW'(1);
              end else begin
                state_q <= StDrop;
              end
            end
          end
          StPre: begin
            if (!crs_q) begin
              state_q <= StIdle;
            end else if (rxd_q == DIB_SFD && pcnt_q != '0) begin
              state_q <= StBody;
              busy    <= 1'b1;
              dcnt_q  <= '0;
              low_q   <= 1'b0;
            end else if (rxd_q == DIB_PRE && pcnt_q != PcntW'(PRE_MAX)) begin
              pcnt_q <= pcnt_q + 1'b1;
            end else begin
              state_q <= StDrop;
              low_q   <= 1'b0;
            end
          end
          StBody: begin
            if (!crs_q && low_q) begin
              // Second low sample ends the frame; the first low dibit is un-counted.
              state_q   <= StIdle;
              busy      <= 1'b0;
              low_q     <= 1'b0;
              align_err <= (dcnt_save_q != 2'd0);
            end else begin
              low_q <= !crs_q;
              if (!crs_q) begin
                dcnt_save_q <= dcnt_q;
              end
              sr_q <= {rxd_q, sr_q[7:2]};
              if (dcnt_q == 2'd3) begin
                data   <= {rxd_q, sr_q[7:2]};
                rdy    <= 1'b1;
                dcnt_q <= '0;
              end else begin
                dcnt_q <= dcnt_q + 1'b1;
              end
            end
          end
          StDrop: begin
            if (!crs_q) begin
              if (low_q) begin
                state_q <= StIdle;
                low_q   <= 1'b0;
              end else begin
                low_q <= 1'b1;
              end
            end else begin
              low_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rmii_rx_deser.sv
// Bench for rmii_rx_deser: frame table, timing corner sequences, randomized frames vs. model.
module tb_rmii_rx_deser;

  localparam int unsigned PreMax   = 40;
  localparam int unsigned Div10    = 10;
  localparam int unsigned SamplePh = 4;

  typedef struct {
    bit       crs;
    bit [1:0] d;
  } smp_t;

  typedef struct {
    bit       fast;
    int       n_pre;
    int       n_bytes;
    int       extra;
    bit       toggle;
    bit [1:0] bad;
    int       exp_rdy;
    int       exp_align;
    int       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fast_eth = 1'b1;
  logic [1:0] rm_rx_data = 2'b00;
  logic       rm_crs_dv = 1'b0;
  logic [7:0] data;
  logic       rdy;
  logic       busy;
  logic       align_err;

  rmii_rx_deser #(
    .PRE_MAX  (PreMax),
    .DIV10    (Div10),
    .SAMPLE_PH(SamplePh)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fast_eth  (fast_eth),
    .rm_rx_data(rm_rx_data),
    .rm_crs_dv (rm_crs_dv),
    .data      (data),
    .rdy       (rdy),
    .busy      (busy),
    .align_err (align_err)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         rdy_cyc[$];
  int         n_align = 0;
  int         align_cyc = -1;
  int         busy_rise_cyc = -1;
  int         busy_fall_cyc = -1;
  int         busy_seen = 0;
  int         viol = 0;
  bit         busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rdy) begin
      got_q.push_back(data);
      rdy_cyc.push_back(cyc);
      if (!busy) viol++;
    end
    if (align_err) begin
      n_align++;
      align_cyc = cyc;
    end
    if (busy && !busy_prev) begin
      busy_rise_cyc = cyc;
      busy_seen++;
    end
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  function automatic void chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endfunction

  smp_t       fr[$];
  int         edge_q[$];
  logic [7:0] sent[$];
  logic [7:0] exp_q[$];
  int         exp_align;
  int         exp_frames;

  task automatic push(input bit c, input bit [1:0] d);
    smp_t s;
    s.crs = c;
    s.d   = d;
    fr.push_back(s);
  endtask

  // Frame: preamble 01s (optional bad dibit mid-way), SFD, bytes LSB dibit first,
  // extra trailing dibits, then carrier low.
  task automatic build(input int n_pre, input int nb, input int extra, input bit toggle,
                       input bit [1:0] bad);
    logic [7:0] v;
    int         j;
    fr.delete();
    sent.delete();
    for (int i = 0; i < n_pre; i++) begin
      if (bad != 2'b00 && i == n_pre / 2) push(1'b1, bad);
      push(1'b1, 2'b01);
    end
    push(1'b1, 2'b11);
    for (int b = 0; b < nb; b++) begin
      if (b == 0) v = 8'h88;
      else if (b == 1) v = 8'hAB;
      else v = 8'($urandom);
      sent.push_back(v);
      for (int k = 0; k < 4; k++) begin
        j = b * 4 + k;
        push((toggle && j >= nb * 4 - 8) ? j[0] : 1'b1, v[2*k+:2]);
      end
    end
    for (int e = 0; e < extra; e++) push(1'b1, 2'($urandom));
    for (int g = 0; g < 4; g++) push(1'b0, 2'b00);
  endtask

  // Reference: parse the sample stream frame by frame.
  task automatic model();
    int         i;
    int         n;
    int         p;
    int         j;
    int         start;
    int         len;
    logic [7:0] b;
    exp_q.delete();
    exp_align  = 0;
    exp_frames = 0;
    n = fr.size();
    i = 0;
    while (i < n) begin
      if (!fr[i].crs) begin
        i++;
        continue;
      end
      p = 0;
      while (i < n && fr[i].crs && fr[i].d == 2'b01 && p <= PreMax) begin
        p++;
        i++;
      end
      if (p > PreMax) begin
        j = i;
      end else begin
        if (i >= n) break;
        if (!fr[i].crs) continue;
        if (p >= 1 && fr[i].d == 2'b11) begin
          start = i + 1;
          j = start;
          while (j + 1 < n && !(!fr[j].crs && !fr[j+1].crs)) j++;
          len = j - start + 1;
          for (int k = 0; k + 4 <= len; k += 4) begin
            b = {fr[start+k+3].d, fr[start+k+2].d, fr[start+k+1].d, fr[start+k].d};
            exp_q.push_back(b);
          end
          if ((len - 1) % 4 != 0) exp_align++;
          exp_frames++;
          i = j + 2;
          continue;
        end
        j = i + 1;
      end
      while (j + 1 < n && !(!fr[j].crs && !fr[j+1].crs)) j++;
      i = j + 2;
    end
  endtask

  task automatic send(input bit fast);
    fast_eth = fast;
    edge_q.delete();
    got_q.delete();
    rdy_cyc.delete();
    n_align   = 0;
    busy_seen = 0;
    foreach (fr[i]) begin
      rm_crs_dv  = fr[i].crs;
      rm_rx_data = fr[i].d;
      edge_q.push_back(cyc + 1);
      repeat (fast ? 1 : Div10) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_model(input string name);
    chk({name, " rdy_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk({name, " data"}, int'(got_q[k]), int'(exp_q[k]));
    chk({name, " align_err"}, n_align, exp_align);
    chk({name, " busy_frames"}, busy_seen, exp_frames);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 31, 2, 0, 1'b0, 2'b00, 2, 0, 1};
    tbl[1]  = '{1'b0, 31, 2, 0, 1'b0, 2'b00, 2, 0, 1};
    tbl[2]  = '{1'b1, 31, 6, 0, 1'b1, 2'b00, 6, 0, 1};
    tbl[3]  = '{1'b1, 31, 3, 2, 1'b0, 2'b00, 3, 1, 1};
    tbl[4]  = '{1'b1, 45, 2, 0, 1'b0, 2'b00, 0, 0, 0};
    tbl[5]  = '{1'b1, 10, 2, 0, 1'b0, 2'b10, 0, 0, 0};
    tbl[6]  = '{1'b0,  5, 3, 1, 1'b0, 2'b00, 3, 1, 1};
    tbl[7]  = '{1'b1,  1, 1, 0, 1'b0, 2'b00, 1, 0, 1};
    tbl[8]  = '{1'b1, 40, 1, 0, 1'b0, 2'b00, 1, 0, 1};
    tbl[9]  = '{1'b1, 41, 1, 0, 1'b0, 2'b00, 0, 0, 0};
    tbl[10] = '{1'b0,  8, 4, 0, 1'b1, 2'b00, 4, 0, 1};
    tbl[11] = '{1'b0, 45, 1, 0, 1'b0, 2'b00, 0, 0, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset data", int'(data), 0);
    chk("reset rdy", int'(rdy), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset align_err", int'(align_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table of whole frames against hand-derived counts and the transmitted bytes.
    for (int t = 0; t < 12; t++) begin
      build(tbl[t].n_pre, tbl[t].n_bytes, tbl[t].extra, tbl[t].toggle, tbl[t].bad);
      send(tbl[t].fast);
      chk($sformatf("tbl%0d rdy_count", t), got_q.size(), tbl[t].exp_rdy);
      for (int k = 0; k < tbl[t].exp_rdy && k < got_q.size(); k++)
        chk($sformatf("tbl%0d data%0d", t, k), int'(got_q[k]), int'(sent[k]));
      chk($sformatf("tbl%0d align_err", t), n_align, tbl[t].exp_align);
      chk($sformatf("tbl%0d busy", t), busy_seen, tbl[t].exp_busy);
    end

    // 100M latency: SFD at index 31, byte dibits 32..39, end-of-frame lows at 40 and 41.
    build(31, 2, 0, 1'b0, 2'b00);
    send(1'b1);
    chk("lat busy_rise", busy_rise_cyc, edge_q[31] + 1);
    chk("lat rdy_count", rdy_cyc.size(), 2);
    chk("lat rdy0", rdy_cyc.size() > 0 ? rdy_cyc[0] : -1, edge_q[35] + 1);
    chk("lat rdy1", rdy_cyc.size() > 1 ? rdy_cyc[1] : -1, edge_q[39] + 1);
    chk("lat busy_fall", busy_fall_cyc, edge_q[41] + 1);

    // 10M byte spacing.
    build(31, 3, 0, 1'b0, 2'b00);
    send(1'b0);
    chk("10M rdy_count", rdy_cyc.size(), 3);
    chk("10M spacing", rdy_cyc.size() > 1 ? rdy_cyc[1] - rdy_cyc[0] : -1, 4 * Div10);
    chk("10M spacing2", rdy_cyc.size() > 2 ? rdy_cyc[2] - rdy_cyc[1] : -1, 4 * Div10);

    // Partial byte: align_err coincides with busy falling.
    build(31, 2, 2, 1'b0, 2'b00);
    send(1'b1);
    chk("align count", n_align, 1);
    chk("align vs busy_fall", align_cyc, busy_fall_cyc);

    // Reset mid-body, then a clean frame.
    build(31, 1, 2, 1'b0, 2'b00);
    got_q.delete();
    for (int i = 0; i < 38; i++) begin
      rm_crs_dv  = fr[i].crs;
      rm_rx_data = fr[i].d;
      @(negedge clk);
    end
    chk("pre_rst busy", int'(busy), 1);
    chk("pre_rst data", int'(data), 8'h88);
    rst       = 1'b1;
    rm_crs_dv = 1'b0;
    @(negedge clk);
    chk("rst data", int'(data), 0);
    chk("rst rdy", int'(rdy), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst align_err", int'(align_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    build(20, 3, 0, 1'b0, 2'b00);
    model();
    send(1'b1);
    check_model("post_rst");

    // Randomized frames against the reference model.
    for (int r = 0; r < 20; r++) begin
      build($urandom_range(1, 44), $urandom_range(1, 6), $urandom_range(0, 2),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
      model();
      send(1'($urandom_range(0, 1)));
      check_model($sformatf("rnd%0d", r));
    end

    chk("rdy_implies_busy", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
